demux_frame_driver: RTL and testbench
=====================================

Name: demux_frame_driver

Overview:
- Upstream feeder for the 1:2 demultiplexer stage.
- Accepts parallel data words tagged with a destination channel through a valid/ready handshake, then serializes each word one bit per clock.
- Drives the demultiplexer's enable, select and data inputs, so each word is steered to channel 0 or channel 1.
- Inserts a programmable idle gap between frames. While the gap runs, the demultiplexer outputs are tri-stated.

Parameters:
- DATA_WIDTH, 8, bits per word; legal range 2..32.
- GAP_CYCLES, 1, idle cycles between frames with Enable_Out low; 0 is legal and means no gap.
- MSB_FIRST, 0, 0 = shift LSB first, 1 = shift MSB first.

Ports:
- Clock_In  input  1  single clock; all state changes on the rising edge.
- Reset_In  input  1  asynchronous, active-high reset.
- Data_In  input  DATA_WIDTH  parallel word to send.
- Channel_In  input  1  destination channel: 0 = Data_0 path, 1 = Data_1 path.
- Valid_In  input  1  Data_In and Channel_In are valid.
- Ready_Out  output  1  block can accept a word this cycle.
- Enable_Out  output  1  drives the demultiplexer enable.
- Select_Out  output  1  drives the demultiplexer select.
- Data_Out  output  1  serial bit; drives the demultiplexer data input.
- Busy_Out  output  1  high from word acceptance until the gap completes.
- Done_Out  output  1  one-cycle pulse after the last bit of a frame.

Behaviour:
- Interface decision: one clock (Clock_In); reset is asynchronous and active-high (Reset_In).
- All outputs are registered.
- Reset values: Ready_Out=0, Enable_Out=0, Select_Out=0, Data_Out=0, Busy_Out=0, Done_Out=0, state=IDLE, bit counter=0, gap counter=0.
- Ready_Out rises on the first clock edge after Reset_In deasserts.
- Reset asserted mid-frame aborts the frame immediately. No Done_Out pulse is produced and the partial word is discarded.
- State IDLE:
  - Ready_Out=1, Enable_Out=0, Data_Out=0; Select_Out holds its last value.
  - A handshake occurs on an edge where Valid_In=1 and Ready_Out=1. Data_In and Channel_In are captured into a shift register and a channel register, and the block moves to SHIFT.
  - On the same edge: Ready_Out goes to 0 and Busy_Out goes to 1.
- State SHIFT:
  - Lasts exactly DATA_WIDTH cycles.
  - Enable_Out=1 and Select_Out=captured channel, both held constant for the whole frame.
  - Data_Out presents bit k in SHIFT cycle k. With MSB_FIRST=0, bit 0 is sent first.
  - Latency: the first bit appears on Data_Out in the cycle after the handshake edge.
  - The bit counter counts 0..DATA_WIDTH-1. Input changes on Data_In, Channel_In and Valid_In are ignored.
- End of frame, on the edge ending the last SHIFT cycle:
  - Enable_Out goes to 0 and Data_Out goes to 0.
  - Done_Out is 1 for exactly the following cycle.
  - If GAP_CYCLES>0: go to GAP and load the gap counter.
  - If GAP_CYCLES=0: go to IDLE with Ready_Out=1 and Busy_Out=0. Done_Out and Ready_Out are high in the same cycle.
- State GAP:
  - Enable_Out=0 and Ready_Out=0 for exactly GAP_CYCLES cycles.
  - Then go to IDLE: Ready_Out=1, Busy_Out=0.
- Back-to-back throughput:
  - GAP_CYCLES=0: one word per DATA_WIDTH+1 cycles (SHIFT plus one IDLE handshake cycle).
  - Otherwise: one word per DATA_WIDTH+GAP_CYCLES+1 cycles.
- Valid_In may stay high continuously; each IDLE cycle with Valid_In=1 accepts exactly one word.
- Select_Out never changes while Enable_Out=1.

Optional Feature:
- Macro: DEMUX_FRAME_DRIVER_PARITY_EN.
- When defined:
  - SHIFT lasts DATA_WIDTH+1 cycles.
  - The extra final cycle drives the even-parity bit (XOR of all data bits) on Data_Out, with Enable_Out=1 and Select_Out unchanged.
  - Done_Out and all later timing shift by one cycle.
- When undefined: no parity bit; timing is exactly as above.

Test Plan:
1. Reset and first word:
   - Stimulus: hold Reset_In=1 for 3 cycles, release; all outputs 0 and Ready_Out=1 one edge later.
   - Stimulus: Data_In=8'hA5, Channel_In=0, Valid_In=1 for one cycle.
   - Response: Enable_Out=1 and Select_Out=0 for 8 cycles; Data_Out sequence 1,0,1,0,0,1,0,1; Done_Out pulses once.
2. Channel 1 with MSB_FIRST=1:
   - Stimulus: Data_In=8'h81, Channel_In=1.
   - Response: Select_Out=1 throughout; Data_Out sequence 1,0,0,0,0,0,0,1.
3. Back-to-back words, GAP_CYCLES=2:
   - Stimulus: Valid_In held high with words 8'h0F then 8'hF0.
   - Response: exactly 2 cycles with Enable_Out=0 between frames; second frame starts 11 cycles after the first.
4. Mid-frame reset:
   - Stimulus: assert Reset_In during bit 4 of 8'hFF.
   - Response: Enable_Out=0 immediately (asynchronously); Done_Out never asserted; next frame after release is bit-exact.
5. GAP_CYCLES=0, inputs changed mid-frame:
   - Stimulus: change Channel_In and Data_In during SHIFT.
   - Response: serialized data and Select_Out are unaffected; Done_Out and Ready_Out are both high in the cycle after the last bit.
6. Parity build with DEMUX_FRAME_DRIVER_PARITY_EN defined:
   - Stimulus: Data_In=8'h07.
   - Response: 9 enabled cycles; the 9th bit is 1; Done_Out occurs one cycle later than in the non-parity build.

Source files
------------

// File: rtl/demux_frame_driver.sv
// -----------------------------------------------------------------------------
// demux_frame_driver
//
// Upstream feeder for a 1:2 demultiplexer. A parallel word and its destination
// channel are accepted over a valid/ready handshake, then serialized one bit
// per clock onto Data_Out while Enable_Out is high and Select_Out holds the
// captured channel. A programmable idle gap (Enable_Out low) separates frames.
//
// Optional build macro:
//   DEMUX_FRAME_DRIVER_PARITY_EN - append one even-parity bit (XOR of all data
//                                  bits) as an extra final enabled cycle.
//
// Parameters:
//   DATA_WIDTH  bits per word (2..32)
//   GAP_CYCLES  idle cycles between frames (0 = no gap)
//   MSB_FIRST   0 = LSB shifted first, 1 = MSB shifted first
//
// Ports:
//   Clock_In    clock, all state changes on the rising edge
//   Reset_In    asynchronous active-high reset
//   Data_In     parallel word to send
//   Channel_In  destination channel (0 = Data_0 path, 1 = Data_1 path)
//   Valid_In    Data_In / Channel_In are valid
//   Ready_Out   block can accept a word this cycle
//   Enable_Out  demultiplexer enable
//   Select_Out  demultiplexer select (constant while Enable_Out is high)
//   Data_Out    serial bit to the demultiplexer data input
//   Busy_Out    high from word acceptance until the gap completes
//   Done_Out    one-cycle pulse after the last bit of a frame
// -----------------------------------------------------------------------------
module demux_frame_driver #(
    parameter int DATA_WIDTH = 8,
    parameter int GAP_CYCLES = 1,
    parameter int MSB_FIRST  = 0
) (
    input  logic                  Clock_In,
    input  logic                  Reset_In,
    input  logic [DATA_WIDTH-1:0] Data_In,
    input  logic                  Channel_In,
    input  logic                  Valid_In,
    output logic                  Ready_Out,
    output logic                  Enable_Out,
    output logic                  Select_Out,
    output logic                  Data_Out,
    output logic                  Busy_Out,
    output logic                  Done_Out
);

`ifdef DEMUX_FRAME_DRIVER_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    localparam int FRAME_LEN = DATA_WIDTH + PARITY_BITS;
    localparam int CNT_W     = $clog2(FRAME_LEN);
    localparam int GAP_W     = $clog2(GAP_CYCLES + 2);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);
    // Gap counter counts down to zero, so it is loaded with GAP_CYCLES-1.
    localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t                  state_reg,   state_next;
    logic [DATA_WIDTH-1:0]   shift_reg,   shift_next;
    logic [CNT_W-1:0]        bit_cnt_reg, bit_cnt_next;
    logic [GAP_W-1:0]        gap_cnt_reg, gap_cnt_next;
    logic                    ready_reg,   ready_next;
    logic                    enable_reg,  enable_next;
    logic                    select_reg,  select_next;
    logic                    data_reg,    data_next;
    logic                    busy_reg,    busy_next;
    logic                    done_reg,    done_next;
`ifdef DEMUX_FRAME_DRIVER_PARITY_EN
    logic                    parity_reg,  parity_next;
`endif

    // Reorder the incoming word so that transmission order is always bit 0
    // first; the shifter then only ever shifts right regardless of MSB_FIRST.
    logic [DATA_WIDTH-1:0] ordered_in;

    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_order
        if (MSB_FIRST != 0) begin : g_msb
            assign ordered_in[gi] = Data_In[DATA_WIDTH-1-gi];
        end else begin : g_lsb
            assign ordered_in[gi] = Data_In[gi];
        end
    end

    always_ff @(posedge Clock_In or posedge Reset_In) begin
        if (Reset_In) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            gap_cnt_reg <= '0;
            ready_reg   <= 1'b0;
            enable_reg  <= 1'b0;
            select_reg  <= 1'b0;
            data_reg    <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
`ifdef DEMUX_FRAME_DRIVER_PARITY_EN
            parity_reg  <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            bit_cnt_reg <= bit_cnt_next;
            gap_cnt_reg <= gap_cnt_next;
            ready_reg   <= ready_next;
            enable_reg  <= enable_next;
            select_reg  <= select_next;
            data_reg    <= data_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
`ifdef DEMUX_FRAME_DRIVER_PARITY_EN
            parity_reg  <= parity_next;
`endif
        end
    end

    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt_reg;
        gap_cnt_next = gap_cnt_reg;
        ready_next   = ready_reg;
        enable_next  = enable_reg;
        select_next  = select_reg;
        data_next    = data_reg;
        busy_next    = busy_reg;
        done_next    = 1'b0;
`ifdef DEMUX_FRAME_DRIVER_PARITY_EN
        parity_next  = parity_reg;
`endif

        case (state_reg)
            IDLE: begin
                ready_next  = 1'b1;
                enable_next = 1'b0;
                data_next   = 1'b0;
                busy_next   = 1'b0;
                // Handshake uses the registered Ready_Out, so the first edge
                // after reset release can never accept a word.
                if (Valid_In && ready_reg) begin
                    shift_next   = ordered_in;
                    select_next  = Channel_In;
                    bit_cnt_next = '0;
                    ready_next   = 1'b0;
                    busy_next    = 1'b1;
                    enable_next  = 1'b1;
                    data_next    = ordered_in[0];
                    state_next   = SHIFT;
`ifdef DEMUX_FRAME_DRIVER_PARITY_EN
                    parity_next  = ^Data_In;
`endif
                end
            end

            SHIFT: begin
                if (bit_cnt_reg == LAST_CNT) begin
                    enable_next  = 1'b0;
                    data_next    = 1'b0;
                    done_next    = 1'b1;
                    bit_cnt_next = '0;
                    if (GAP_CYCLES > 0) begin
                        state_next   = GAP;
                        gap_cnt_next = GAP_LOAD;
                    end else begin
                        // No gap: Ready_Out rises together with Done_Out.
                        state_next = IDLE;
                        ready_next = 1'b1;
                        busy_next  = 1'b0;
                    end
                end else begin
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                    shift_next   = shift_reg >> 1;
                    data_next    = shift_reg[1];
`ifdef DEMUX_FRAME_DRIVER_PARITY_EN
                    if (bit_cnt_reg == CNT_W'(DATA_WIDTH - 1)) begin
                        data_next = parity_reg;
                    end
`endif
                end
            end

            GAP: begin
                if (gap_cnt_reg == '0) begin
                    state_next = IDLE;
                    ready_next = 1'b1;
                    busy_next  = 1'b0;
                end else begin
                    gap_cnt_next = gap_cnt_reg - 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign Ready_Out  = ready_reg;
    assign Enable_Out = enable_reg;
    assign Select_Out = select_reg;
    assign Data_Out   = data_reg;
    assign Busy_Out   = busy_reg;
    assign Done_Out   = done_reg;

endmodule

// File: tb/tb_demux_frame_driver.sv
// -----------------------------------------------------------------------------
// tb_demux_frame_driver
//
// Three differently configured instances run side by side:
//   inst0: GAP_CYCLES=1, LSB first (defaults)
//   inst1: GAP_CYCLES=2, MSB first
//   inst2: GAP_CYCLES=0, LSB first
// Each has a driver that pushes accepted words into a scoreboard queue and a
// monitor that predicts every output from the frame timeline arithmetic
// (handshake edge h, frame length L, gap G) and compares once per cycle, plus
// a whole-frame comparison when a frame retires.
// -----------------------------------------------------------------------------
module tb_demux_frame_driver;

`ifdef DEMUX_FRAME_DRIVER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int inst,
                         input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s inst%0d edge %0d: got %h expected %h",
                      name, inst, edge_n, got, exp);
    endtask

    typedef struct {
        logic [31:0] data;
        logic        ch;
        int          h;
    } frame_t;

    for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
        localparam int G = (gi == 0) ? 1 : (gi == 1) ? 2 : 0;
        localparam int M = (gi == 1) ? 1 : 0;
        localparam int L = W + PAR;

        logic         rst   = 1'b1;
        logic [W-1:0] din   = '0;
        logic         ch    = 1'b0;
        logic         valid = 1'b0;
        logic ready, en, sel, dout, busy, done;

        frame_t sbq[$];
        int     next_accept = 0;
        int     ready_from  = 0;
        bit     fin = 1'b0;

        demux_frame_driver #(
            .DATA_WIDTH (W),
            .GAP_CYCLES (G),
            .MSB_FIRST  (M)
        ) dut (
            .Clock_In   (clk),
            .Reset_In   (rst),
            .Data_In    (din),
            .Channel_In (ch),
            .Valid_In   (valid),
            .Ready_Out  (ready),
            .Enable_Out (en),
            .Select_Out (sel),
            .Data_Out   (dout),
            .Busy_Out   (busy),
            .Done_Out   (done)
        );

        // k-th transmitted bit of a word; index W is the parity bit.
        function automatic logic exp_bit(input logic [31:0] d, input int k);
            logic [W-1:0] w;
            w = d[W-1:0];
            if (k == W) return ^w;
            return (M != 0) ? w[W-1-k] : w[k];
        endfunction

        // ---------------- monitor ----------------
        initial begin : mon
            int n, k;
            logic last_sel;
            logic [31:0] got_word, exp_word;
            logic e_ready, e_en, e_sel, e_dat, e_busy, e_done;
            last_sel = 1'b0;
            got_word = '0;
            forever begin
                @(negedge clk);
                n = edge_n;
                e_ready = 0; e_en = 0; e_sel = 0; e_dat = 0; e_busy = 0; e_done = 0;
                if (rst) begin
                    sbq.delete();
                    last_sel = 1'b0;
                end else begin
                    while (sbq.size() > 0 && n > sbq[0].h + L + G) begin
                        exp_word = '0;
                        for (int b = 0; b < L; b++) exp_word[b] = exp_bit(sbq[0].data, b);
                        $display("inst%0d frame h=%0d data=%h ch=%0d serial=%h expected=%h",
                                 gi, sbq[0].h, sbq[0].data[W-1:0], sbq[0].ch, got_word, exp_word);
                        check("frame_word", gi, got_word, exp_word);
                        last_sel = sbq[0].ch;
                        void'(sbq.pop_front());
                    end
                    if (sbq.size() > 0 && n >= sbq[0].h) begin
                        k       = n - sbq[0].h;
                        e_en    = (k < L);
                        e_dat   = e_en ? exp_bit(sbq[0].data, k) : 1'b0;
                        e_done  = (k == L);
                        e_busy  = (k < L + G);
                        e_sel   = sbq[0].ch;
                        e_ready = !e_busy;
                        if (k == 0) got_word = '0;
                        if (k < L) got_word[k] = dout;
                    end else begin
                        e_ready = (n >= ready_from);
                        e_sel   = last_sel;
                    end
                end
                check("outputs{rdy,en,sel,dat,busy,done}", gi,
                      {26'd0, ready, en, sel, dout, busy, done},
                      {26'd0, e_ready, e_en, e_sel, e_dat, e_busy, e_done});
            end
        end

        // ---------------- driver ----------------
        task automatic drive(input logic v, input logic [W-1:0] d, input logic c,
                             output bit acc);
            @(posedge clk);
            #1;
            valid = v;
            din   = d;
            ch    = c;
            acc   = 1'b0;
            if (v && !rst && (edge_n + 1 >= next_accept)) begin
                sbq.push_back('{data: 32'(d), ch: c, h: edge_n + 1});
                next_accept = edge_n + 1 + L + G + 1;
                acc = 1'b1;
            end
        endtask

        task automatic send(input logic [W-1:0] d, input logic c);
            bit acc;
            acc = 1'b0;
            for (int t = 0; t < 64 && !acc; t++) drive(1'b1, d, c, acc);
            if (!acc) begin
                n_checks++;
                $display("FAIL send_timeout inst%0d: got no acceptance expected one within 64 cycles", gi);
            end
        endtask

        task automatic idle(input int cycles);
            bit acc;
            for (int t = 0; t < cycles; t++) drive(1'b0, W'($urandom), 1'($urandom), acc);
        endtask

        // Called right after a posedge (+#1) or at time zero.
        task automatic do_reset(input int cycles, input bit chk);
            rst   = 1'b1;
            valid = 1'b0;
            if (chk) begin
                #1;
                check("async_reset{en,dat,done,busy,rdy}", gi,
                      {27'd0, en, dout, done, busy, ready}, 32'd0);
            end
            repeat (cycles) @(posedge clk);
            #1;
            rst         = 1'b0;
            ready_from  = edge_n + 1;
            next_accept = edge_n + 2;
        endtask

        initial begin : drv
            bit acc;
            do_reset(3, 1'b0);
            send(8'hA5, 1'b0);
            idle(L + G + 3);
            send(8'h81, 1'b1);
            idle(L + G + 3);
            send(8'h0F, 1'b0);
            send(8'hF0, 1'b1);
            idle(L + G + 3);
            // Abort during bit 4 of 0xFF.
            send(8'hFF, 1'b1);
            repeat (5) drive(1'b0, 8'h00, 1'b0, acc);
            do_reset(2, 1'b1);
            send(8'hA5, 1'b0);
            idle(L + G + 3);
            send(8'h07, 1'b1);
            idle(L + G + 3);
            // Random traffic; inputs keep changing during frames.
            repeat (200) drive(($urandom_range(0, 3) != 0), W'($urandom), 1'($urandom), acc);
            idle(L + G + 4);
            fin = 1'b1;
        end
    end

    initial begin
        for (int i = 0; i < 20000; i++) begin
            @(posedge clk);
            if (g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin) break;
        end
        if (!(g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin)) begin
            n_checks++;
            $display("FAIL run_timeout: got unfinished drivers expected all finished within 20000 cycles");
        end
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
